// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin / fixed priority arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    function automatic int clamp_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/priority_encoder_param.sv
// Combinational encoder: index of the highest set bit of vec, plus found.
module priority_encoder_param
    import arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clamp_idx_w(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    // Later (higher) set bits overwrite earlier ones, so the highest wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered arbiter with held grant/ack handshake; fixed or round-robin
// priority searched downward from ptr with wraparound.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int RR_MODE = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic                                ack,
    output logic [NUM_REQ-1:0]                  grant,
    output logic [clamp_idx_w(NUM_REQ)-1:0]     grant_idx,
    output logic                                grant_valid
);

    localparam int IDX_W = clamp_idx_w(NUM_REQ);
    localparam logic [IDX_W-1:0] TOP = IDX_W'(NUM_REQ - 1);

    state_t           state;
    state_t           state_n;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_n;
    logic [IDX_W-1:0] acked_ptr;
    logic [IDX_W-1:0] search_ptr;
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0] enc_idx;
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic             accept;
    logic             load;

    logic [NUM_REQ-1:0] grant_n;
    logic [IDX_W-1:0]   grant_idx_n;
    logic               grant_valid_n;

    assign accept    = (state == GRANT) && ack;
    assign load      = (state == IDLE) || accept;
    assign acked_ptr = (grant_idx == '0) ? TOP : grant_idx - 1'b1;

    // An accepted grant searches with the already-advanced pointer.
    assign search_ptr = (RR_MODE != 0 && accept) ? acked_ptr : ptr;

    // Rotate so that requester search_ptr lands on the top bit.
    always_comb begin
        rot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            rot[j] = req[(j + int'(search_ptr) + 1) % NUM_REQ];
        end
    end

    priority_encoder_param #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_enc (
        .vec   (rot),
        .idx   (enc_idx),
        .found (found)
    );

    always_comb begin
        win_idx = IDX_W'((int'(enc_idx) + int'(search_ptr) + 1) % NUM_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= TOP;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            grant       <= grant_n;
            grant_idx   <= grant_idx_n;
            grant_valid <= grant_valid_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = found ? GRANT : IDLE;
            GRANT:   state_n = (ack && !found) ? IDLE : GRANT;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ptr_n         = ptr;
        grant_n       = grant;
        grant_idx_n   = grant_idx;
        grant_valid_n = grant_valid;
        if (RR_MODE != 0 && accept) begin
            ptr_n = acked_ptr;
        end
        if (load) begin
            grant_valid_n = found;
            grant_idx_n   = found ? win_idx : '0;
            grant_n       = found ? (NUM_REQ'(1) << win_idx) : '0;
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench: one fixed-priority and one round-robin instance, 4 requesters.
module tb_rr_priority_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_f;
    logic       ack_f;
    logic [3:0] grant_f;
    logic [1:0] idx_f;
    logic       valid_f;
    logic [3:0] req_r;
    logic       ack_r;
    logic [3:0] grant_r;
    logic [1:0] idx_r;
    logic       valid_r;

    int total  = 0;
    int passed = 0;

    rr_priority_arbiter #(.NUM_REQ(4), .RR_MODE(0)) u_fix (
        .clk         (clk),
        .rst         (rst),
        .req         (req_f),
        .ack         (ack_f),
        .grant       (grant_f),
        .grant_idx   (idx_f),
        .grant_valid (valid_f)
    );

    rr_priority_arbiter #(.NUM_REQ(4), .RR_MODE(1)) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (req_r),
        .ack         (ack_r),
        .grant       (grant_r),
        .grant_idx   (idx_r),
        .grant_valid (valid_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_r(input string tag, input logic [1:0] idx,
                         input logic v);
        logic [3:0] g;
        g = v ? (4'b0001 << idx) : 4'b0000;
        check({tag, ".valid"}, 8'(valid_r), 8'(v));
        check({tag, ".idx"}, 8'(idx_r), v ? 8'(idx) : 8'h0);
        check({tag, ".grant"}, 8'(grant_r), 8'(g));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        req_f = '0;
        ack_f = 1'b0;
        req_r = '0;
        ack_r = 1'b0;
        #1;
        check("rst_async.valid", 8'(valid_r), 8'h0);
        check("rst_async.grant", 8'(grant_f), 8'h0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk_r("idle_no_req", 2'd0, 1'b0);
        check("fix_idle.valid", 8'(valid_f), 8'h0);

        // Fixed priority: 1010 -> index 3, held without ack.
        req_f = 4'b1010;
        step();
        check("fix_c1.grant", 8'(grant_f), 8'h08);
        check("fix_c1.idx", 8'(idx_f), 8'h3);
        check("fix_c1.valid", 8'(valid_f), 8'h1);
        req_f = 4'b0010;
        step();
        check("fix_c2.grant", 8'(grant_f), 8'h08);
        req_f = 4'b1010;
        step();
        check("fix_c3.idx", 8'(idx_f), 8'h3);
        ack_f = 1'b1;
        step();
        check("fix_reack.idx", 8'(idx_f), 8'h3);
        check("fix_reack.valid", 8'(valid_f), 8'h1);
        req_f = 4'b0000;
        step();
        check("fix_drain.valid", 8'(valid_f), 8'h0);
        check("fix_drain.grant", 8'(grant_f), 8'h0);
        ack_f = 1'b0;

        // Round-robin with all requesting and ack every cycle.
        req_r = 4'b1111;
        step();
        chk_r("rr_all0", 2'd3, 1'b1);
        ack_r = 1'b1;
        step();
        chk_r("rr_all1", 2'd2, 1'b1);
        step();
        chk_r("rr_all2", 2'd1, 1'b1);
        step();
        chk_r("rr_all3", 2'd0, 1'b1);
        step();
        chk_r("rr_all4", 2'd3, 1'b1);
        step();
        chk_r("rr_all5", 2'd2, 1'b1);
        req_r = 4'b0000;
        step();
        chk_r("rr_all_drain", 2'd0, 1'b0);
        ack_r = 1'b0;

        // Reset puts ptr back to 3 before the 0101 sequence.
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        req_r = 4'b0101;
        step();
        chk_r("rr_0101_a", 2'd2, 1'b1);
        ack_r = 1'b1;
        step();
        chk_r("rr_0101_b", 2'd0, 1'b1);
        step();
        chk_r("rr_0101_c", 2'd2, 1'b1);
        step();
        chk_r("rr_0101_d", 2'd0, 1'b1);
        req_r = 4'b0001;
        step();
        chk_r("rr_sole", 2'd0, 1'b1);
        req_r = 4'b0000;
        step();
        chk_r("rr_sole_drain", 2'd0, 1'b0);
        ack_r = 1'b0;

        // Grant held while req drops and ack stays low.
        req_r = 4'b0100;
        step();
        chk_r("rr_hold0", 2'd2, 1'b1);
        req_r = 4'b0000;
        step();
        chk_r("rr_hold1", 2'd2, 1'b1);
        step();
        chk_r("rr_hold2", 2'd2, 1'b1);
        ack_r = 1'b1;
        step();
        chk_r("rr_release", 2'd0, 1'b0);
        step();
        chk_r("rr_idle_ack", 2'd0, 1'b0);
        ack_r = 1'b0;

        // ptr is now 1: grant index 1, then async reset mid-cycle.
        req_r = 4'b0010;
        step();
        chk_r("rr_idx1", 2'd1, 1'b1);
        req_r = 4'b1111;
        step();
        chk_r("rr_idx1_hold", 2'd1, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk_r("rr_async_rst", 2'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk_r("rr_after_rst", 2'd3, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
